vedic8_seq: RTL and testbench

Sequencer that computes an unsigned 8x8 product by time-multiplexing a single combinational 4x4 `vedic4` multiplier over four cycles and accumulating the shifted partial products. It sits between a requester with a valid/ready input channel and a consumer with a valid/ready output channel. It trades the area of four 4x4 units for a fixed four-cycle multiply latency.

---
 rtl/vedic8_seq.sv | 89 ++++++++
 tb/tb_vedic8_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vedic8_seq.sv
// vedic8_seq: 8x8 unsigned multiplier time-multiplexing one vedic4 core over four cycles
module vedic2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic [1:0] m;
  logic [1:0] h;
  assign m = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
  assign h = {1'b0, a[1] & b[1]} + {1'b0, m[1]};
  assign p = {h, m[0], a[0] & b[0]};
endmodule

module vedic4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;
  vedic2 u0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic2 u1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic2 u2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic2 u3 (.a(a[3:2]), .b(b[3:2]), .p(q3));
  assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

module vedic8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        busy,
  output logic [7:0]  op_count
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_nx;
  logic [1:0]  step;
  logic [7:0]  ra, rb, pp;
  logic [15:0] acc, addend;
  logic        accept, handoff;
  // step[0] picks the multiplicand nibble, step[1] the multiplier nibble
  vedic4 u_mul (
    .a(step[0] ? ra[7:4] : ra[3:0]),
    .b(step[1] ? rb[7:4] : rb[3:0]),
    .p(pp)
  );
  assign addend = step == 2'd3 ? {pp, 8'b0} : step == 2'd0 ? {8'b0, pp} : {4'b0, pp, 4'b0};
  assign accept  = ena && state == IDLE && in_valid;
  assign handoff = ena && state == DONE && out_ready;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = accept ? MUL :
               (ena && state == MUL && step == 2'd3) ? DONE :
               handoff ? IDLE : state;
  always_comb begin
    in_ready  = ena && state == IDLE;
    out_valid = ena && state == DONE;
    busy      = state == MUL;
    out_p     = acc;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      step     <= '0;
      acc      <= '0;
      ra       <= '0;
      rb       <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        ra   <= in_a;
        rb   <= in_b;
        acc  <= '0;
        step <= '0;
      end
      if (ena && state == MUL) begin
        acc  <= acc + addend;
        step <= step + 2'd1;
      end
      if (handoff) op_count <= op_count + 8'd1;
    end
endmodule

// File: tb/tb_vedic8_seq.sv
// tb_vedic8_seq: directed and random checks of vedic8_seq against a scoreboard of reference products
module tb_vedic8_seq;
  logic        clk = 1'b0;
  logic        rst_n, ena, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  in_a, in_b, op_count;
  logic [15:0] out_p;
  logic [15:0] sb[$];
  logic [15:0] exp_p;
  logic [7:0]  opc;
  int          vectors = 0, miscompares = 0;
  int          lat, cnt;

  vedic8_seq dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    int k = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    sb.push_back(16'(a) * 16'(b));
  endtask

  task automatic wait_out(output int l);
    l = 0;
    while (!out_valid && l < 50) begin
      tick();
      l++;
    end
    check("out_valid_seen", out_valid, 1);
  endtask

  task automatic handoff();
    check("sb_nonempty", sb.size() != 0, 1);
    exp_p = sb.size() != 0 ? sb.pop_front() : 16'hxxxx;
    check("out_p", out_p, exp_p);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    opc++;
    check("op_count", op_count, opc);
    check("in_ready_after", in_ready, 1);
  endtask

  task automatic full_op(input logic [7:0] a, input logic [7:0] b);
    accept(a, b);
    wait_out(lat);
    check("latency", lat, 4);
    handoff();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; opc = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 8'h00);

    accept(8'hFF, 8'hFF);
    check("busy_after_accept", busy, 1);
    wait_out(lat);
    check("latency_ff", lat, 4);
    check("out_p_ff", out_p, 16'hFE01);
    handoff();
    check("op_count_first", op_count, 8'h01);

    full_op(8'h00, 8'hA5);
    full_op(8'h0F, 8'hF0);
    full_op(8'h12, 8'h34);

    // back-pressure: product held while a competing request waits
    accept(8'hC3, 8'h7E);
    wait_out(lat);
    in_a = 8'h21; in_b = 8'h43; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_p", out_p, 16'(8'hC3) * 16'(8'h7E));
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      tick();
    end
    handoff();
    check("bp_idle", busy, 0);
    tick();
    in_valid = 1'b0;
    sb.push_back(16'h21 * 16'h43);
    check("bp_next_accept", busy, 1);
    wait_out(lat);
    check("bp_latency", lat, 4);
    handoff();

    // ena stall of 3 cycles starting in step 1
    accept(8'h37, 8'h5B);
    cnt = 1;
    tick();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 0);
      tick();
      cnt++;
    end
    ena = 1'b1;
    wait_out(lat);
    check("stall_latency", cnt + lat, 7);
    check("stall_out_p", out_p, 16'h138D);
    handoff();

    // reset during step 2 discards the operation
    accept(8'h9A, 8'hBC);
    void'(sb.pop_back());
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    opc = '0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_p", out_p, 16'h0000);
    check("mid_rst_op_count", op_count, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    full_op(8'h03, 8'h05);

    // random sweep also carries op_count through its wrap
    for (int i = 0; i < 500; i++) begin
      full_op(8'($urandom_range(255)), 8'($urandom_range(255)));
      if (i == 253) check("wrap_ff", op_count, 8'hFF);
      if (i == 254) check("wrap_00", op_count, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
